// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the IFU/LSU memory port arbiter:
//   - arb_state_t : arbiter FSM state encodings (ARB_IDLE / ARB_REQ / ARB_WAIT)
//   - arb_owner_t : requester IDs (OWN_IFU / OWN_LSU)
//   - mem_req_t   : the request fields latched at grant time
//   - cnt_width() : bit width needed to hold a counter value 0..max_val
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  // Number of requesters sharing the port (IFU, LSU).
  localparam int unsigned NUM_REQ = 2;

  // Response timer width; covers the full 1..65535 timeout range.
  localparam int unsigned TIMER_W = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wen;
  } mem_req_t;

  // Width of a counter that must represent 0..max_val (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the IFU request/response, LSU request/response and memory port
// handshake signals of the arbiter.
//   modport master : the arbiter's view (accepts requests, drives the memory port)
//   modport slave  : the surrounding system's view (IFU, LSU and memory models)
// Ports (all logic):
//   ifu_req_valid, ifu_addr[31:0]                          : IFU request
//   ifu_req_ready, ifu_rsp_valid, ifu_rdata[31:0]          : IFU accept / response
//   lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb : LSU request
//   lsu_req_ready, lsu_rsp_valid, lsu_rdata[31:0]          : LSU accept / response
//   mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb : memory request
//   mem_req_ready, mem_rsp_valid, mem_rdata[31:0]          : memory accept / response
interface mem_port_arbiter_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// mem_arb_timer
// Up-counter with synchronous clear and count enable. 'hit' is high while the
// count equals LIMIT. Clear has priority over enable.
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset (count -> 0)
//   clr   in  : synchronous clear
//   en    in  : increment by one
//   hit   out : count == LIMIT
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_W,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign hit = (count_reg == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-ported unified memory between the instruction fetch unit
// (IFU) and the load/store unit (LSU). One request is in flight at a time:
// IDLE picks a winner and latches its fields, REQ presents them to memory
// until accepted, WAIT_RSP routes the response back to the owner. LSU has
// priority, but IFU is forced after MAX_LSU_STREAK consecutive LSU grants
// taken while IFU was waiting. A response that does not arrive within TIMEOUT
// WAIT_RSP cycles is aborted with rdata 0 and sets the sticky err flag.
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset
//   bus       : mem_port_arbiter_if.master (IFU, LSU and memory handshakes)
//   err   out : sticky response-timeout flag, cleared only by reset
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus,
  output logic                err
);

  localparam int unsigned         STREAK_W   = cnt_width(MAX_LSU_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

  arb_state_t          state_reg, state_next;
  arb_owner_t          owner_reg, owner_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  mem_req_t            req_reg, req_next;
  logic                err_reg, err_next;

  logic ifu_win, lsu_win;
  logic timer_clr, timer_en, timer_hit;
  logic rsp_fire, rsp_abort;
  logic mem_req_valid_o;
  logic [NUM_REQ-1:0] req_ready_vec;
  logic [NUM_REQ-1:0] rsp_valid_vec;
  logic [31:0]        rsp_rdata;
  logic [31:0]        rsp_rdata_vec [NUM_REQ];

  // IFU is only chosen when LSU is absent or has used up its streak.
  assign ifu_win = bus.ifu_req_valid && (!bus.lsu_req_valid || (streak_reg == STREAK_MAX));
  assign lsu_win = bus.lsu_req_valid && !ifu_win;

  // A real response in the same cycle as the timer hit wins over the abort.
  assign rsp_fire  = (state_reg == ARB_WAIT) && (bus.mem_rsp_valid || timer_hit);
  assign rsp_abort = (state_reg == ARB_WAIT) && timer_hit && !bus.mem_rsp_valid;
  assign rsp_rdata = bus.mem_rsp_valid ? bus.mem_rdata : 32'h0;

  assign timer_clr = (state_reg == ARB_REQ) && bus.mem_req_ready;
  assign timer_en  = (state_reg == ARB_WAIT) && !bus.mem_rsp_valid && !timer_hit;

  mem_arb_timer #(
    .WIDTH (TIMER_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .hit   (timer_hit)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ARB_IDLE: if (ifu_win || lsu_win)  state_next = ARB_REQ;
      ARB_REQ:  if (bus.mem_req_ready)   state_next = ARB_WAIT;
      ARB_WAIT: if (rsp_fire)            state_next = ARB_IDLE;
      default:                           state_next = ARB_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready_vec   = '0;
    mem_req_valid_o = 1'b0;
    if (state_reg == ARB_IDLE) begin
      req_ready_vec[OWN_IFU] = ifu_win;
      req_ready_vec[OWN_LSU] = lsu_win;
    end
    if (state_reg == ARB_REQ) begin
      mem_req_valid_o = 1'b1;
    end
  end

  // Grant bookkeeping: owner, latched request, LSU streak and sticky error.
  always_comb begin
    owner_next  = owner_reg;
    req_next    = req_reg;
    streak_next = streak_reg;
    err_next    = err_reg || rsp_abort;
    if (state_reg == ARB_IDLE) begin
      if (ifu_win) begin
        owner_next  = OWN_IFU;
        req_next    = '{addr: bus.ifu_addr, wdata: 32'h0, wstrb: 4'h0, wen: 1'b0};
        streak_next = '0;
      end else if (lsu_win) begin
        owner_next = OWN_LSU;
        req_next   = '{addr: bus.lsu_addr, wdata: bus.lsu_wdata,
                       wstrb: bus.lsu_wstrb, wen: bus.lsu_wen};
        // Only grants taken over a waiting IFU count towards starvation.
        if (bus.ifu_req_valid && (streak_reg != STREAK_MAX)) begin
          streak_next = streak_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg  <= OWN_IFU;
      req_reg    <= '0;
      streak_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      owner_reg  <= owner_next;
      req_reg    <= req_next;
      streak_reg <= streak_next;
      err_reg    <= err_next;
    end
  end

  // Response routing: only the owner sees rsp_valid; idle rdata is zero.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid_vec[gi] = rsp_fire && (owner_reg == ((gi == 0) ? OWN_IFU : OWN_LSU));
      assign rsp_rdata_vec[gi] = rsp_valid_vec[gi] ? rsp_rdata : 32'h0;
    end
  endgenerate

  assign bus.ifu_req_ready = req_ready_vec[OWN_IFU];
  assign bus.lsu_req_ready = req_ready_vec[OWN_LSU];
  assign bus.ifu_rsp_valid = rsp_valid_vec[OWN_IFU];
  assign bus.lsu_rsp_valid = rsp_valid_vec[OWN_LSU];
  assign bus.ifu_rdata     = rsp_rdata_vec[0];
  assign bus.lsu_rdata     = rsp_rdata_vec[1];

  assign bus.mem_req_valid = mem_req_valid_o;
  assign bus.mem_addr      = req_reg.addr;
  assign bus.mem_wdata     = req_reg.wdata;
  assign bus.mem_wstrb     = req_reg.wstrb;
  assign bus.mem_wen       = req_reg.wen;

  assign err = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: inputs driven 1 time unit after the
// rising edge, outputs sampled on the falling edge, every expected value
// written out by hand.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  logic err;

  int n_checks = 0;
  int n_errors = 0;
  int hs_count = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_LSU_STREAK (4),
    .TIMEOUT        (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side handshake counter.
  always @(posedge clk) begin
    if (bus.mem_req_valid && bus.mem_req_ready) hs_count <= hs_count + 1;
  end

  // One line per completed transaction.
  always @(posedge clk) begin
    if (rst_n && bus.ifu_rsp_valid)
      $display("txn IFU rdata=%08h err=%0b", bus.ifu_rdata, err);
    if (rst_n && bus.lsu_rsp_valid)
      $display("txn LSU rdata=%08h err=%0b", bus.lsu_rdata, err);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [9:0]  exp_ifu;
    logic [31:0] d;
    logic        early;
    int          hs_base;

    rst_n             = 1'b0;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wstrb     = 4'h0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    smp();
    chk1 ("rst_ifu_ready", bus.ifu_req_ready, 1'b0);
    chk1 ("rst_lsu_ready", bus.lsu_req_ready, 1'b0);
    chk1 ("rst_mem_valid", bus.mem_req_valid, 1'b0);
    chk1 ("rst_ifu_rsp",   bus.ifu_rsp_valid, 1'b0);
    chk1 ("rst_lsu_rsp",   bus.lsu_rsp_valid, 1'b0);
    chk32("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk32("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    chk1 ("rst_mem_wen",   bus.mem_wen, 1'b0);
    chk1 ("rst_err",       err, 1'b0);
    cyc();
    rst_n = 1'b1;

    // ---- 1: IFU only, minimum latency; stray rsp in REQ ignored ----
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    bus.mem_req_ready = 1'b1;
    smp();
    chk1 ("t1_c0_ifu_ready", bus.ifu_req_ready, 1'b1);
    chk1 ("t1_c0_lsu_ready", bus.lsu_req_ready, 1'b0);
    chk1 ("t1_c0_mem_valid", bus.mem_req_valid, 1'b0);
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'hBAD0_BAD0;
    smp();
    chk1 ("t1_c1_mem_valid", bus.mem_req_valid, 1'b1);
    chk32("t1_c1_mem_addr",  bus.mem_addr, 32'h8000_0000);
    chk1 ("t1_c1_mem_wen",   bus.mem_wen, 1'b0);
    chk32("t1_c1_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    chk1 ("t1_c1_stray_rsp", bus.ifu_rsp_valid, 1'b0);
    cyc();
    bus.mem_rdata = 32'h0000_0413;
    smp();
    chk1 ("t1_c2_ifu_rsp",   bus.ifu_rsp_valid, 1'b1);
    chk32("t1_c2_ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
    chk1 ("t1_c2_lsu_rsp",   bus.lsu_rsp_valid, 1'b0);
    chk32("t1_c2_lsu_rdata", bus.lsu_rdata, 32'h0);
    chk1 ("t1_c2_mem_valid", bus.mem_req_valid, 1'b0);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    smp();
    chk1 ("t1_c3_ifu_rsp",   bus.ifu_rsp_valid, 1'b0);
    chk32("t1_c3_ifu_rdata", bus.ifu_rdata, 32'h0);

    // ---- 2: both valid with streak 0: LSU store first, then IFU ----
    cyc();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wstrb     = 4'b0011;
    smp();
    chk1 ("t2_lsu_ready", bus.lsu_req_ready, 1'b1);
    chk1 ("t2_ifu_ready", bus.ifu_req_ready, 1'b0);
    cyc();
    bus.lsu_req_valid = 1'b0;
    smp();
    chk1 ("t2_mem_valid", bus.mem_req_valid, 1'b1);
    chk1 ("t2_mem_wen",   bus.mem_wen, 1'b1);
    chk32("t2_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h3);
    chk32("t2_mem_addr",  bus.mem_addr,  32'h0000_1000);
    chk32("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk1 ("t2_ifu_ready_busy", bus.ifu_req_ready, 1'b0);
    cyc();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h0;
    smp();
    chk1 ("t2_lsu_rsp", bus.lsu_rsp_valid, 1'b1);
    chk1 ("t2_ifu_rsp", bus.ifu_rsp_valid, 1'b0);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    smp();
    chk1 ("t2_ifu_ready_next", bus.ifu_req_ready, 1'b1);
    cyc();
    bus.ifu_req_valid = 1'b0;
    smp();
    chk32("t2_ifu_mem_addr",  bus.mem_addr, 32'h8000_0004);
    chk1 ("t2_ifu_mem_wen",   bus.mem_wen, 1'b0);
    chk32("t2_ifu_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    cyc();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h1234_5678;
    smp();
    chk1 ("t2_ifu_rsp",   bus.ifu_rsp_valid, 1'b1);
    chk32("t2_ifu_rdata", bus.ifu_rdata, 32'h1234_5678);
    cyc();
    bus.mem_rsp_valid = 1'b0;

    // ---- 3: both held valid: L L L L I L L L L I ----
    exp_ifu           = 10'b10000_10000;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wstrb     = 4'hF;
    bus.mem_rsp_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d             = 32'hA5A5_0000 + 32'(k);
      bus.mem_rdata = d;
      smp();
      chk1 ("t3_grant_ifu", bus.ifu_req_ready, exp_ifu[k]);
      chk1 ("t3_grant_lsu", bus.lsu_req_ready, !exp_ifu[k]);
      cyc();
      cyc();
      smp();
      chk1 ("t3_rsp_ifu",   bus.ifu_rsp_valid, exp_ifu[k]);
      chk1 ("t3_rsp_lsu",   bus.lsu_rsp_valid, !exp_ifu[k]);
      chk32("t3_rdata_ifu", bus.ifu_rdata, exp_ifu[k] ? d : 32'h0);
      chk32("t3_rdata_lsu", bus.lsu_rdata, exp_ifu[k] ? 32'h0 : d);
      cyc();
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_rsp_valid = 1'b0;

    // ---- 4: mem_req_ready low for 10 cycles ----
    hs_base           = hs_count;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_2000;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h1111_1111;
    bus.lsu_wstrb     = 4'hF;
    bus.mem_req_ready = 1'b0;
    smp();
    chk1 ("t4_lsu_ready", bus.lsu_req_ready, 1'b1);
    cyc();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'hFFFF_0000;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk1 ("t4_stall_valid", bus.mem_req_valid, 1'b1);
      chk32("t4_stall_addr",  bus.mem_addr, 32'h0000_2000);
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    smp();
    chk1 ("t4_accept_valid", bus.mem_req_valid, 1'b1);
    chk32("t4_accept_wstrb", {28'h0, bus.mem_wstrb}, 32'hF);
    cyc();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'hCAFE_F00D;
    smp();
    chk1 ("t4_wait_valid", bus.mem_req_valid, 1'b0);
    chk32("t4_handshakes", 32'(hs_count - hs_base), 32'd1);
    chk1 ("t4_lsu_rsp",    bus.lsu_rsp_valid, 1'b1);
    chk32("t4_lsu_rdata",  bus.lsu_rdata, 32'hCAFE_F00D);
    cyc();
    bus.mem_rsp_valid = 1'b0;

    // ---- 5: response in the cycle the timer reaches TIMEOUT is normal ----
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_3000;
    smp();
    chk1 ("t5_lsu_ready", bus.lsu_req_ready, 1'b1);
    cyc();
    bus.lsu_req_valid = 1'b0;
    smp();
    chk1 ("t5_mem_valid", bus.mem_req_valid, 1'b1);
    cyc();
    early = 1'b0;
    for (int i = 0; i < 255; i++) begin
      smp();
      early = early | bus.lsu_rsp_valid | bus.ifu_rsp_valid;
      cyc();
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h600D_DA7A;
    smp();
    chk1 ("t5_no_early_rsp", early, 1'b0);
    chk1 ("t5_lsu_rsp",      bus.lsu_rsp_valid, 1'b1);
    chk32("t5_lsu_rdata",    bus.lsu_rdata, 32'h600D_DA7A);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    smp();
    chk1 ("t5_err", err, 1'b0);

    // ---- 6: no response for 255 WAIT cycles -> abort ----
    cyc();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0100;
    bus.mem_rdata     = 32'hFFFF_FFFF;
    smp();
    chk1 ("t6_ifu_ready", bus.ifu_req_ready, 1'b1);
    cyc();
    bus.ifu_req_valid = 1'b0;
    cyc();
    early = 1'b0;
    for (int i = 0; i < 255; i++) begin
      smp();
      early = early | bus.ifu_rsp_valid | bus.lsu_rsp_valid;
      cyc();
    end
    smp();
    chk1 ("t6_no_early_rsp", early, 1'b0);
    chk1 ("t6_ifu_rsp",      bus.ifu_rsp_valid, 1'b1);
    chk32("t6_ifu_rdata",    bus.ifu_rdata, 32'h0);
    chk1 ("t6_lsu_rsp",      bus.lsu_rsp_valid, 1'b0);
    chk1 ("t6_err_same",     err, 1'b0);
    cyc();
    smp();
    chk1 ("t6_err_set",   err, 1'b1);
    chk1 ("t6_rsp_clear", bus.ifu_rsp_valid, 1'b0);

    // ---- 7: normal transaction after timeout, err stays set ----
    cyc();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0200;
    smp();
    chk1 ("t7_ifu_ready", bus.ifu_req_ready, 1'b1);
    cyc();
    bus.ifu_req_valid = 1'b0;
    cyc();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h0010_0073;
    smp();
    chk1 ("t7_ifu_rsp",   bus.ifu_rsp_valid, 1'b1);
    chk32("t7_ifu_rdata", bus.ifu_rdata, 32'h0010_0073);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    smp();
    chk1 ("t7_err_sticky", err, 1'b1);

    // ---- 8: reset mid-transaction abandons it ----
    cyc();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_4000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'h0000_0055;
    bus.lsu_wstrb     = 4'b0001;
    smp();
    chk1 ("t8_lsu_ready", bus.lsu_req_ready, 1'b1);
    cyc();
    bus.lsu_req_valid = 1'b0;
    cyc();
    rst_n             = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h7777_7777;
    smp();
    chk1 ("t8_lsu_rsp",    bus.lsu_rsp_valid, 1'b0);
    chk1 ("t8_ifu_rsp",    bus.ifu_rsp_valid, 1'b0);
    chk1 ("t8_err",        err, 1'b0);
    chk1 ("t8_mem_valid",  bus.mem_req_valid, 1'b0);
    chk32("t8_mem_addr",   bus.mem_addr,  32'h0);
    chk32("t8_mem_wdata",  bus.mem_wdata, 32'h0);
    cyc();
    rst_n = 1'b1;
    smp();
    chk1 ("t8_idle_ignores_rsp", bus.lsu_rsp_valid, 1'b0);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    smp();
    chk1 ("t8_ifu_ready_after", bus.ifu_req_ready, 1'b1);
    cyc();
    bus.ifu_req_valid = 1'b0;
    smp();
    chk32("t8_ifu_mem_addr", bus.mem_addr, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single-ported unified memory between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC core. It accepts one request at a time and drives it to the memory port with a valid/ready handshake. It routes the response back to the requester that issued it. LSU has priority, with a bounded-starvation guarantee for IFU and a response timeout that flags a hung memory.

## Interface
- `MAX_LSU_STREAK`, default 4: consecutive LSU grants allowed while IFU waits before IFU is forced.
- `TIMEOUT`, default 255: cycles allowed in WAIT_RSP before abort; range 1..65535.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ifu_req_valid` in 1: IFU request.
- `ifu_req_ready` out 1: IFU request accepted this cycle.
- `ifu_addr` in 32: fetch address.
- `ifu_rsp_valid` out 1: IFU response valid.
- `ifu_rdata` out 32: fetched word.
- `lsu_req_valid` in 1: LSU request.
- `lsu_req_ready` out 1: LSU request accepted this cycle.
- `lsu_addr` in 32: load/store address.
- `lsu_wen` in 1: 1 = store.
- `lsu_wdata` in 32: store data.
- `lsu_wstrb` in 4: byte strobes.
- `lsu_rsp_valid` out 1: LSU response valid (load data or store ack).
- `lsu_rdata` out 32: load word.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts.
- `mem_addr`, `mem_wdata` out 32: latched request fields.
- `mem_wen` out 1: latched request field.
- `mem_wstrb` out 4: latched request field.
- `mem_rsp_valid` in 1: memory response.
- `mem_rdata` in 32: memory read data.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP; a 1-bit owner register (IFU/LSU).
- IDLE: if any req_valid, choose a winner. LSU wins unless `ifu_req_valid` is high and `streak == MAX_LSU_STREAK`. Assert the winner's `*_req_ready` combinationally that cycle. Latch addr/wdata/wstrb/wen into the request registers; IFU requests latch wen=0 and wstrb=0. Set owner and go to REQ.
- REQ: `mem_req_valid=1` and mem_* driven from the latched registers, held stable. On `mem_req_ready`, go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP: `mem_rsp_valid` sampled only in this state. On the response, assert the owner's `*_rsp_valid` combinationally for that cycle, with `*_rdata = mem_rdata`, and go to IDLE.
- Streak counter:
  - increments on an LSU grant while `ifu_req_valid` is high;
  - clears on any IFU grant;
  - saturates at `MAX_LSU_STREAK`.
- Timeout:
  - the counter increments each WAIT_RSP cycle without a response;
  - when it reaches `TIMEOUT`, set `err`, pulse the owner's `rsp_valid` with rdata = 0, and go to IDLE;
  - `err` clears only on reset.
- Non-owner rsp_valid is always 0; rdata of an invalid response is 0.
- A requester that drops valid before ready is simply not granted. No request is ever lost after ready.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, owner IFU, streak 0, timer 0, `err` 0; all ready/valid outputs 0; mem_* data 0.
- Minimum latency is accept in cycle 0, `mem_req_valid` in cycle 1, and response in cycle 2. The next grant is possible in the cycle after the response (cycle 3).
- Memory responds no earlier than the cycle after the request handshake. A `mem_rsp_valid` outside WAIT_RSP is ignored.
- Both requesters valid in IDLE is resolved per the priority rule; only one ready is high.
- Timeout boundary: a response arriving in the same cycle the counter reaches `TIMEOUT` is treated as a normal response, with no `err`.
- Reset mid-transaction abandons it: no rsp_valid is emitted, and the memory side must also be reset.

## Structure
- Shared header (alongside `TYPES.v`) holds the `ARB_IDLE/ARB_REQ/ARB_WAIT` state encodings and the `OWN_IFU/OWN_LSU` IDs.
- One sub-module, `mem_arb_timer`: a parameterised counter with clear, enable and a `hit` output, instantiated for the timeout. The streak counter is inline.

## Test plan
- IFU only, fetch at 0x80000000, memory ready immediately, rdata 0x00000413 next cycle: `ifu_req_ready` in cycle 0, `mem_req_valid` in cycle 1, and `ifu_rsp_valid` with 0x00000413 in cycle 2.
- IFU and LSU valid together in IDLE with streak 0: LSU is granted and `mem_wen`/`mem_wstrb` reflect the LSU store (wstrb 4'b0011); IFU is granted in the next IDLE.
- IFU held valid and LSU valid continuously: exactly 4 LSU grants, then an IFU grant, then the pattern repeats.
- `mem_req_ready` held low for 10 cycles: mem_* stay stable, and there is one handshake, no duplicate.
- No response for 255 WAIT cycles: the owner receives `rsp_valid` with rdata 0, `err` goes to 1 and stays 1 through subsequent normal transactions until `rst_n` is asserted low.
